// File: rtl/dram_access_ctrl.sv
// Write-port arbiter, clear sequencer and read pass-through for one dual-port distributed RAM.
// Optional macro WR_BYPASS_EN forwards the in-flight write word to rd_data on an address match.
module dram_access_ctrl #(
    parameter int unsigned          addr_bits = 6,
    parameter int unsigned          data_bits = 8,
    parameter logic [data_bits-1:0] clr_val   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_clr,
    output logic                 clr_busy,
    output logic                 clr_done,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [addr_bits-1:0] req0_addr,
    input  logic [data_bits-1:0] req0_data,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [addr_bits-1:0] req1_addr,
    input  logic [data_bits-1:0] req1_data,
    input  logic [addr_bits-1:0] rd_addr,
    output logic [data_bits-1:0] rd_data,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [addr_bits-1:0] ram_wr_addr,
    output logic [data_bits-1:0] ram_d,
    output logic [addr_bits-1:0] ram_rd_addr,
    input  logic [data_bits-1:0] ram_dpo
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t               state, state_nxt;
    logic [addr_bits-1:0] clr_cnt, clr_cnt_nxt;
    logic                 last_grant, last_grant_nxt;
    logic                 ram_en_nxt, ram_we_nxt, clr_done_nxt, clr_busy_nxt;
    logic [addr_bits-1:0] ram_wr_addr_nxt;
    logic [data_bits-1:0] ram_d_nxt;

    always_comb begin
        state_nxt       = state;
        clr_cnt_nxt     = clr_cnt;
        last_grant_nxt  = last_grant;
        req0_ready      = 1'b0;
        req1_ready      = 1'b0;
        ram_en_nxt      = 1'b0;
        ram_we_nxt      = 1'b0;
        ram_wr_addr_nxt = ram_wr_addr;
        ram_d_nxt       = ram_d;
        clr_done_nxt    = 1'b0;
        clr_busy_nxt    = clr_busy;
        case (state)
            CLEAR: begin
                ram_en_nxt      = 1'b1;
                ram_we_nxt      = 1'b1;
                ram_wr_addr_nxt = clr_cnt;
                ram_d_nxt       = clr_val;
                clr_cnt_nxt     = clr_cnt + 1'b1;
                clr_busy_nxt    = 1'b1;
                if (clr_cnt == '1) begin
                    state_nxt    = RUN;
                    clr_done_nxt = 1'b1;
                    clr_busy_nxt = 1'b0;
                end
            end
            RUN: begin
                clr_busy_nxt = 1'b0;
                if (start_clr) begin
                    state_nxt    = CLEAR;
                    clr_cnt_nxt  = '0;
                    clr_busy_nxt = 1'b1;
                end else begin
                    // last_grant=1 means requester 1 won last, so requester 0 wins a tie
                    if (req0_valid && (!req1_valid || last_grant))
                        req0_ready = 1'b1;
                    else if (req1_valid)
                        req1_ready = 1'b1;

                    if (req0_ready) begin
                        ram_en_nxt      = 1'b1;
                        ram_we_nxt      = 1'b1;
                        ram_wr_addr_nxt = req0_addr;
                        ram_d_nxt       = req0_data;
                        last_grant_nxt  = 1'b0;
                    end else if (req1_ready) begin
                        ram_en_nxt      = 1'b1;
                        ram_we_nxt      = 1'b1;
                        ram_wr_addr_nxt = req1_addr;
                        ram_d_nxt       = req1_data;
                        last_grant_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CLEAR;
            clr_cnt     <= '0;
            last_grant  <= 1'b1;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_wr_addr <= '0;
            ram_d       <= '0;
            clr_done    <= 1'b0;
            clr_busy    <= 1'b1;
        end else begin
            state       <= state_nxt;
            clr_cnt     <= clr_cnt_nxt;
            last_grant  <= last_grant_nxt;
            ram_en      <= ram_en_nxt;
            ram_we      <= ram_we_nxt;
            ram_wr_addr <= ram_wr_addr_nxt;
            ram_d       <= ram_d_nxt;
            clr_done    <= clr_done_nxt;
            clr_busy    <= clr_busy_nxt;
        end
    end

    assign ram_rd_addr = rd_addr;

`ifdef WR_BYPASS_EN
    assign rd_data = (ram_we && (ram_wr_addr == rd_addr)) ? ram_d : ram_dpo;
`else
    assign rd_data = ram_dpo;
`endif

endmodule

// File: doc/dram_access_ctrl.md
Name: dram_access_ctrl

Overview:
Access controller for one dual-port distributed RAM of the kind the decoder uses for per-block side info (intra pred mode, ref_idx, mvp).
- Shares the single RAM write port between two requesters using round-robin arbitration with valid/ready handshakes.
- Clears the whole RAM to a fixed value after reset and on request.
- Passes the read address through to the RAM's second read port.
- Sits between the CU/PU parsing stages and the dram instance; the controller drives all RAM control signals.

Parameters:
addr_bits, 6, RAM address width; depth = 1<<addr_bits
data_bits, 8, RAM word width
clr_val, 0, data_bits-wide value written to every word during a clear

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start_clr  input  1  pulse: start a full clear sweep
clr_busy  output  1  high while a clear is in progress
clr_done  output  1  one-cycle pulse on the last clear write
req0_valid  input  1  requester 0 write valid
req0_ready  output  1  requester 0 accepted
req0_addr  input  addr_bits  requester 0 write address
req0_data  input  data_bits  requester 0 write data
req1_valid / req1_ready / req1_addr / req1_data  same as req0, for requester 1
rd_addr  input  addr_bits  read address
rd_data  output  data_bits  read data (combinational)
ram_en  output  1  RAM enable
ram_we  output  1  RAM write enable
ram_wr_addr  output  addr_bits  RAM write address
ram_d  output  data_bits  RAM write data
ram_rd_addr  output  addr_bits  RAM read address; equals rd_addr (combinational)
ram_dpo  input  data_bits  RAM read data from ram_rd_addr

Behaviour:
- Reset values: ram_en=0, ram_we=0, ram_wr_addr=0, ram_d=0, clr_done=0, clr_busy=1, state=CLEAR, clr_cnt=0, last_grant=1 (requester 0 wins the first tie). rst held high keeps these values.
- States:
  - CLEAR: every cycle register ram_we=1, ram_en=1, ram_wr_addr=clr_cnt, ram_d=clr_val; then clr_cnt++.
  - CLEAR -> RUN: when clr_cnt = 2^addr_bits-1 is issued. clr_cnt wraps to 0.
  - RUN -> CLEAR: when start_clr=1.
- Clear timing: with rst deasserted at cycle 0, writes to addresses 0..63 appear on ram_* in cycles 1..64. clr_done=1 in cycle 64 only. clr_busy=1 in cycles 0..63 and 0 from cycle 64.
- Ready signals: req0_ready/req1_ready are 0 in CLEAR and 0 in any RUN cycle where start_clr=1. Otherwise they are computed combinationally:
  - only req0_valid -> req0_ready=1
  - only req1_valid -> req1_ready=1
  - both valid -> grant requester != last_grant
- Handshake = valid&ready. A handshake in cycle n:
  - drives ram_we=1, ram_en=1, ram_wr_addr/ram_d = winner's addr/data, registered, visible in cycle n+1;
  - sets last_grant=winner.
  - No handshake in RUN -> ram_we=0, ram_en=0 next cycle; address/data hold.
- Throughput: one write per cycle. Requesters must hold valid/addr/data stable until ready.
- Read path: ram_rd_addr=rd_addr; rd_data=ram_dpo, zero latency. Reading an address written in cycle n returns the new data from cycle n+2.
- start_clr during CLEAR is ignored; the sweep continues, with no restart and no extra clr_done.
- rst mid-clear: restart the sweep at address 0 after release.
- rst mid-RUN: a pending registered write is dropped.

Optional Feature:
WR_BYPASS_EN
- Defined: if ram_we=1 and ram_wr_addr==rd_addr in the current cycle, rd_data=ram_d; otherwise rd_data=ram_dpo. A read issued the cycle after the handshake then sees the new data.
- Undefined: rd_data=ram_dpo always. No comparator is built.

Test Plan:
- Reset, then hold reqs idle -> ram_we=1 cycles 1..64 with ram_wr_addr 0..63 and ram_d=0; clr_done pulse in cycle 64 only; a model RAM reads all zeros afterwards.
- RUN, req0 and req1 both valid continuously (addr 5/9, data 0xAA/0x55) -> grants alternate req0, req1, req0…; ram_wr_addr sequence 5, 9, 5, 9 one cycle later.
- RUN, only req1 valid for 4 cycles (addrs 1..4, data 0x10..0x13) -> req1_ready=1 for 4 cycles; back-to-back writes in the following cycles; req0_ready stays 0.
- RUN with both valid; start_clr pulse -> both readies 0 that cycle; 64-cycle sweep follows; no handshakes until clr_busy falls; a second start_clr mid-sweep causes no extra clr_done.
- Handshake req0 addr 7 data 0x3C at cycle n, rd_addr=7 at n+1 -> with WR_BYPASS_EN rd_data=0x3C; without it rd_data=old value, and 0x3C at n+2.
- rst asserted at clear address 30 for 2 cycles -> sweep restarts at 0; clr_done comes 64 cycles after release.
